// File: rtl/mips_cpu_muldiv_ctrl.sv
// rtl/mips_cpu_muldiv_ctrl.sv - MIPS HI/LO owner with iterative multiply/divide sequencer
module mips_cpu_muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [5:0]  insop,
  input  logic [5:0]  func,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] orig_q, orig_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic        is_div_q, is_div_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic is_r, is_mfhi, is_mthi, is_mflo, is_mtlo;
  logic is_mult, is_multu, is_div, is_divu;
  logic uses_hilo, accept, signed_op;
  logic [31:0] abs_rs, abs_rt;

  assign is_r     = (insop == 6'b000000);
  assign is_mfhi  = is_r & (func == 6'b010000);
  assign is_mthi  = is_r & (func == 6'b010001);
  assign is_mflo  = is_r & (func == 6'b010010);
  assign is_mtlo  = is_r & (func == 6'b010011);
  assign is_mult  = is_r & (func == 6'b011000);
  assign is_multu = is_r & (func == 6'b011001);
  assign is_div   = is_r & (func == 6'b011010);
  assign is_divu  = is_r & (func == 6'b011011);

  assign uses_hilo = is_mfhi | is_mthi | is_mflo | is_mtlo |
                     is_mult | is_multu | is_div | is_divu;
  assign busy      = (state_q != S_IDLE);
  assign stall     = valid & busy & uses_hilo;
  assign accept    = valid & uses_hilo & ~stall;
  assign signed_op = is_mult | is_div;

  assign abs_rs = (signed_op & rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
  assign abs_rt = (signed_op & rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

  // acc holds {partial product, remaining multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [32:0] mul_sum;
  logic [33:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    div_diff = {1'b0, acc_q[63:31]} - {2'b00, opb_q};
    prod_fix = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;
    quot_fix = (sa_q ^ sb_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = sa_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    orig_d   = orig_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mthi) hi_d = rs_data;
          if (is_mtlo) lo_d = rs_data;
          if (is_mult | is_multu | is_div | is_divu) begin
            cnt_d  = 5'd0;
            sa_d   = signed_op & rs_data[31];
            sb_d   = signed_op & rt_data[31];
            orig_d = rs_data;
            div0_d = (rt_data == 32'd0);
          end
          if (is_mult | is_multu) begin
            acc_d    = {32'd0, abs_rt};
            opb_d    = abs_rs;
            is_div_d = 1'b0;
            state_d  = S_MUL;
          end
          if (is_div | is_divu) begin
            acc_d    = {32'd0, abs_rs};
            opb_d    = abs_rt;
            is_div_d = 1'b1;
            state_d  = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_DIV: begin
        if (!div_diff[33]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
        else               acc_d = {acc_q[62:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (div0_q) begin
          hi_d = orig_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      orig_q   <= 32'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      orig_q   <= orig_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// tb/tb_mips_cpu_muldiv_ctrl.sv - randomized self-checking bench for mips_cpu_muldiv_ctrl
module tb_mips_cpu_muldiv_ctrl;

  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD  = 6'h20;

  logic        clk = 1'b0;
  logic        reset, valid;
  logic [5:0]  insop, func;
  logic [31:0] rs_data, rt_data;
  logic        stall, busy;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mips_cpu_muldiv_ctrl dut (
    .clk(clk), .reset(reset), .valid(valid), .insop(insop), .func(func),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .busy(busy),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic on magnitudes, signs applied afterwards
  function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb;
    longint unsigned ua, ub, ma, mb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = 32'd0;
    lo = 32'd0;
    if (f == F_MULT || f == F_MULTU) begin
      p  = (f == F_MULT) ? 64'(sa * sb) : 64'(ua * ub);
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      if (f == F_DIV) begin
        ma = (sa < 0) ? longint'(-sa) : longint'(sa);
        mb = (sb < 0) ? longint'(-sb) : longint'(sb);
      end else begin
        ma = ua;
        mb = ub;
      end
      q = ma / mb;
      r = ma % mb;
      if (f == F_DIV && ((sa < 0) != (sb < 0))) q = -q;
      if (f == F_DIV && (sa < 0)) r = -r;
      lo = q[31:0];
      hi = r[31:0];
    end
  endfunction

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e_hi, e_lo;
    int n;
    logic held_ok;
    ref_op(f, a, b, e_hi, e_lo);
    insop = 6'd0; func = f; rs_data = a; rt_data = b; valid = 1'b1;
    tick;
    valid = 1'b0; func = F_ADD; rs_data = $urandom; rt_data = $urandom;
    n = 0;
    held_ok = 1'b1;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (hi_out !== m_hi || lo_out !== m_lo) held_ok = 1'b0;
      tick;
    end
    checks++;
    if (n != 33) begin errors++; $display("FAIL busy_len f=%h a=%h b=%h: got %0d want 33", f, a, b, n); end
    checks++;
    if (held_ok !== 1'b1) begin errors++; $display("FAIL hold_during_busy f=%h: got changed want held %h/%h", f, m_hi, m_lo); end
    m_hi = e_hi;
    m_lo = e_lo;
    checks++;
    if (hi_out !== m_hi) begin errors++; $display("FAIL hi f=%h a=%h b=%h: got %h want %h", f, a, b, hi_out, m_hi); end
    checks++;
    if (lo_out !== m_lo) begin errors++; $display("FAIL lo f=%h a=%h b=%h: got %h want %h", f, a, b, lo_out, m_lo); end
  endtask

  task automatic move_to(input logic [5:0] f, input logic [31:0] a);
    insop = 6'd0; func = f; rs_data = a; rt_data = $urandom; valid = 1'b1;
    tick;
    valid = 1'b0;
    if (f == F_MTHI) m_hi = a;
    if (f == F_MTLO) m_lo = a;
    checks++;
    if (hi_out !== m_hi || lo_out !== m_lo || busy !== 1'b0) begin
      errors++;
      $display("FAIL move f=%h: got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0", f, hi_out, lo_out, busy, m_hi, m_lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; valid = 1'b0; insop = 6'd0; func = F_ADD; rs_data = 32'd0; rt_data = 32'd0;
    tick; tick;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (hi_out !== 32'd0 || lo_out !== 32'd0) begin errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi_out, lo_out); end
    valid = 1'b1; func = F_MFHI;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    valid = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_directed;
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op(F_MULT,  32'hFFFF_FFFD, 32'h0000_0005);
    run_op(F_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    run_op(F_DIVU,  32'h0000_0007, 32'h0000_0000);
    run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(F_DIV,   32'hFFFF_FFF0, 32'h0000_0000);
    checks++;
    if (hi_out !== 32'hFFFF_FFF0 || lo_out !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div0_signed: got %h/%h want FFFFFFF0/FFFFFFFF", hi_out, lo_out);
    end
  endtask

  task automatic test_mthi_mtlo;
    move_to(F_MTHI, 32'h1234_5678);
    move_to(F_MTLO, 32'h9ABC_DEF0);
    move_to(F_MFHI, 32'hDEAD_BEEF);
    move_to(F_MFLO, 32'hCAFE_F00D);
  endtask

  task automatic test_other;
    insop = 6'h01; func = F_MTHI; rs_data = 32'h5555_AAAA; valid = 1'b1;
    tick;
    insop = 6'h00; func = F_ADD;
    tick;
    insop = 6'h23; func = F_MULT; rt_data = 32'd3;
    tick;
    valid = 1'b0; insop = 6'h00;
    checks++;
    if (hi_out !== m_hi || lo_out !== m_lo || busy !== 1'b0) begin
      errors++; $display("FAIL other_no_effect: got hi=%h lo=%h busy=%b want %h/%h/0", hi_out, lo_out, busy, m_hi, m_lo);
    end
  endtask

  task automatic test_stall;
    logic [31:0] e_hi, e_lo;
    int bad_stall, bad_add;
    ref_op(F_MULT, 32'h0001_0000, 32'hFFFF_0000, e_hi, e_lo);
    insop = 6'd0; func = F_MULT; rs_data = 32'h0001_0000; rt_data = 32'hFFFF_0000; valid = 1'b1;
    tick;
    func = F_MFHI; rs_data = 32'h0; rt_data = 32'h0;
    bad_stall = 0; bad_add = 0;
    for (int i = 1; i <= 33; i++) begin
      if (i == 7 || i == 20) begin
        func = F_ADD; #1;
        if (stall !== 1'b0) bad_add++;
        func = F_MFHI; #1;
      end else begin
        #1;
      end
      if (stall !== 1'b1) bad_stall++;
      tick;
    end
    checks++;
    if (bad_stall != 0) begin errors++; $display("FAIL stall_window: got %0d low cycles want 0", bad_stall); end
    checks++;
    if (bad_add != 0) begin errors++; $display("FAIL stall_add: got %0d stalled cycles want 0", bad_add); end
    m_hi = e_hi; m_lo = e_lo;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_release: got stall=%b busy=%b want 0/0", stall, busy); end
    checks++;
    if (hi_out !== m_hi) begin errors++; $display("FAIL mfhi_after_mult: got %h want %h", hi_out, m_hi); end
    tick;
    valid = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic test_random;
    logic [5:0] ops [4];
    ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 5);
      if (r < 4) run_op(ops[r], pick_operand(), pick_operand());
      else       move_to((r == 4) ? F_MTHI : F_MTLO, $urandom);
    end
  endtask

  task automatic test_reset_abort;
    int n;
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    insop = 6'd0; func = F_DIVU; rs_data = 32'h0000_1234; rt_data = 32'h0000_0007; valid = 1'b1;
    tick;
    valid = 1'b0;
    for (int i = 1; i < 10; i++) tick;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    checks++;
    if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      errors++; $display("FAIL abort_reset: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi_out, lo_out);
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) n++;
      tick;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL abort_no_writeback: got %0d bad cycles want 0", n); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_mthi_mtlo;
    test_other;
    test_stall;
    test_random;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv_ctrl.md
Name: mips_cpu_muldiv_ctrl

Overview:
Sequencer and owner of the architectural HI/LO register pair for the MIPS core.
- Accepts MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO from decode.
- Runs multiply and divide iteratively, one bit per cycle, over 33 busy cycles.
- Interlocks any HI/LO access behind an in-flight operation by asserting a stall to the pipeline.

Parameters:
none

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
valid  input  1  decode stage holds a valid instruction this cycle
insop  input  6  instruction opcode field [31:26]
func  input  6  instruction function field [5:0]
rs_data  input  32  register file read port A (dividend, multiplicand, MTHI/MTLO source)
rt_data  input  32  register file read port B (divisor, multiplier)
stall  output  1  combinational; pipeline must hold the current instruction
busy  output  1  registered; a multiply or divide is in progress
hi_out  output  32  registered architectural HI
lo_out  output  32  registered architectural LO

Behaviour:
- Decode (only when insop==000000):
  - func 010000 = MFHI, 010001 = MTHI, 010010 = MFLO, 010011 = MTLO.
  - func 011000 = MULT, 011001 = MULTU, 011010 = DIV, 011011 = DIVU.
  - All other encodings are "other": never stall, never modify state.
- HI/LO use: an instruction uses HI/LO when it is any of the eight encodings above.
- stall = valid & busy & (instruction uses HI/LO). An instruction is accepted when valid & uses HI/LO & !stall.
- Reset (synchronous): on a rising edge with reset high:
  - state=IDLE, busy=0, hi_out=0, lo_out=0, internal counter and accumulators cleared.
  - This applies in every state; an in-flight operation is aborted and produces no result.
- States: IDLE, MUL, DIV, FIX. busy = (state != IDLE).
- IDLE:
  - Accepted MTHI: hi_out <= rs_data at the same edge; lo_out unchanged.
  - Accepted MTLO: lo_out <= rs_data at the same edge; hi_out unchanged.
  - MFHI/MFLO: no state change; the pipeline reads hi_out/lo_out directly.
  - Accepted MULT/MULTU: latch operands, counter=0, go to MUL.
  - Accepted DIV/DIVU: latch operands, counter=0, go to DIV.
  - Signed ops (MULT, DIV) latch absolute values of both operands and record the sign flags. Unsigned ops latch operands unchanged with sign flags cleared.
- MUL: shift-add, one multiplier bit per cycle into a 64-bit accumulator. After 32 iterations go to FIX.
- DIV: restoring division, one quotient bit per cycle. After 32 iterations go to FIX.
- FIX (one cycle): applies sign correction, writes hi_out/lo_out, returns to IDLE.
  - Multiply: negate the 64-bit product if the operand signs differ. HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, negated if the operand signs differ. HI = remainder, negated if the dividend was negative (remainder takes the dividend's sign).
- Divide by zero (rt_data==0, DIV or DIVU): no sign correction. Result LO=FFFFFFFF, HI=rs_data (original, unmodified value). Iterations still take the full count.
- Signed overflow: DIV 80000000 / FFFFFFFF -> LO=80000000, HI=00000000.
- Timing for a MULT/DIV accepted in cycle C:
  - busy=1 in cycles C+1 through C+33.
  - New hi_out/lo_out are visible from cycle C+34.
  - hi_out/lo_out hold their old values throughout cycles C+1..C+33.
- A stalled instruction is presented again with valid held and is accepted in cycle C+34.
  - Example: MFHI right after MULT reads the new HI with no extra bubble.
- Non-HI/LO instructions in cycles C+1..C+33 never stall.
- While busy, inputs other than reset are ignored apart from driving stall.

Test Plan:
- MULTU rs=FFFFFFFF rt=00000002, valid one cycle -> busy high exactly 33 cycles, then hi_out=00000001, lo_out=FFFFFFFE.
- MULT rs=FFFFFFFD (-3) rt=00000005 -> hi_out=FFFFFFFF, lo_out=FFFFFFF1.
- DIV rs=FFFFFFF9 (-7) rt=00000002 -> lo_out=FFFFFFFD, hi_out=FFFFFFFF. DIVU rs=00000007 rt=00000000 -> lo_out=FFFFFFFF, hi_out=00000007.
- MULT issued, then MFHI held valid the next cycle -> stall=1 for cycles C+1..C+33, 0 in C+34. An ADD (func 100000) in the same window -> stall=0.
- MTHI rs=12345678 then MTLO rs=9ABCDEF0 in IDLE -> hi_out=12345678 and lo_out=9ABCDEF0 one edge after each. DIV 80000000/FFFFFFFF -> lo_out=80000000, hi_out=0.
- DIVU started, reset asserted at busy cycle 10 -> next edge busy=0, hi_out=lo_out=0, no later write-back.
